bcd_scan_disp: RTL and testbench

- Downstream consumer of cascaded 4-bit decade up-counter stages: takes NDIG packed BCD digits, each digit being one stage's Q3..Q0.
- Latches the digits into a shadow register on a strobe.
- Time-multiplexes the digits onto one 7-segment bus with one-hot digit enables, using an internal scan prescaler.
- Flags any latched non-decimal nibble.

---
 rtl/bcd_scan_disp.sv | 196 +++++++++++++++++++
 tb/tb_bcd_scan_disp.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_disp.sv
// ---------------------------------------------------------------------------
// bcd_scan_disp
//
// Time-multiplexed 7-segment driver for NDIG packed BCD digits, such as the
// outputs of a chain of decade counters. A LATCH strobe copies the digits and
// their decimal-point requests into a shadow register. An internal prescaler
// gives each digit SCAN_DIV enabled clocks before the scan moves on to the
// next digit. ERR flags any shadowed nibble above 9.
//
// Optional feature (compile-time macro BCD_SCAN_LZB_EN): leading-zero
// blanking. Digit i (i >= 1) is suppressed when every digit j >= i holds 0
// with no decimal point requested. Digit 0 is never suppressed.
//
// Parameters:
//   NDIG     : number of digits scanned (2..8)
//   SCAN_DIV : enabled clocks per digit slot (>= 1)
//
// Ports:
//   CLK    in   clock, rising edge
//   CS     in   synchronous active-high reset, clears all state
//   EN     in   scan enable; low freezes the scan and blanks the display
//   LATCH  in   level-sensitive capture strobe for BCD and DP_IN
//   BCD    in   packed digits, digit i = BCD[4i+3:4i], digit 0 = LSD
//   DP_IN  in   decimal-point request per digit
//   AN     out  one-hot digit enable, active-high
//   SEG    out  segments {g,f,e,d,c,b,a}, active-high
//   DP     out  decimal point of the active digit
//   ERR    out  high while any shadowed digit is greater than 9
// ---------------------------------------------------------------------------
module bcd_scan_disp #(
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                CLK,
    input  logic                CS,
    input  logic                EN,
    input  logic                LATCH,
    input  logic [4*NDIG-1:0]   BCD,
    input  logic [NDIG-1:0]     DP_IN,
    output logic [NDIG-1:0]     AN,
    output logic [6:0]          SEG,
    output logic                DP,
    output logic                ERR
);

    localparam int PSW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW  = $clog2(NDIG);

    localparam logic [PSW-1:0] PS_MAX  = PSW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]  DIG_MAX = DW'(NDIG - 1);

    // Segment patterns {g,f,e,d,c,b,a}; any non-decimal nibble shows 'E'.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h79;
        endcase
        return s;
    endfunction

    // Scan state
    logic [PSW-1:0]    ps_q,  ps_d;
    logic [DW-1:0]     dig_q, dig_d;

    // Shadow copy of the counter digits
    logic [4*NDIG-1:0] sh_bcd_q, sh_bcd_d;
    logic [NDIG-1:0]   sh_dp_q,  sh_dp_d;

    // Registered outputs
    logic [NDIG-1:0]   an_q,  an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q,  dp_d;
    logic              err_q, err_d;

    // Combinational helpers
    logic [3:0]        cur_nib;
    logic [NDIG-1:0]   blank;

    // -----------------------------------------------------------------------
    // Prescaler and digit index
    // -----------------------------------------------------------------------
    always_comb begin
        ps_d  = ps_q;
        dig_d = dig_q;
        if (EN) begin
            if (ps_q == PS_MAX) begin
                ps_d  = '0;
                dig_d = (dig_q == DIG_MAX) ? '0 : dig_q + 1'b1;
            end else begin
                ps_d  = ps_q + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Shadow capture
    // -----------------------------------------------------------------------
    always_comb begin
        sh_bcd_d = sh_bcd_q;
        sh_dp_d  = sh_dp_q;
        if (LATCH) begin
            sh_bcd_d = BCD;
            sh_dp_d  = DP_IN;
        end
    end

    // -----------------------------------------------------------------------
    // Error flag: any shadowed nibble above 9, independent of EN
    // -----------------------------------------------------------------------
    always_comb begin
        err_d = 1'b0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (sh_bcd_q[4*i +: 4] > 4'd9) begin
                err_d = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Leading-zero blanking mask
    // -----------------------------------------------------------------------
`ifdef BCD_SCAN_LZB_EN
    // Walk down from the most significant digit; a digit stays blank only
    // while it and everything above it are zero with no decimal point.
    always_comb begin
        logic zero_above;
        blank      = '0;
        zero_above = 1'b1;
        for (int unsigned i = NDIG - 1; i >= 1; i--) begin
            zero_above = zero_above & (sh_bcd_q[4*i +: 4] == 4'd0) & ~sh_dp_q[i];
            blank[i]   = zero_above;
        end
    end
`else
    always_comb begin
        blank = '0;
    end
`endif

    // -----------------------------------------------------------------------
    // Output register next-state. Uses the index before this edge's update,
    // so the display trails the scan index by one clock.
    // -----------------------------------------------------------------------
    always_comb begin
        cur_nib = sh_bcd_q[{dig_q, 2'b00} +: 4];
        an_d    = '0;
        seg_d   = '0;
        dp_d    = 1'b0;
        if (EN && !blank[dig_q]) begin
            an_d[dig_q] = 1'b1;
            seg_d       = seg_decode(cur_nib);
            dp_d        = sh_dp_q[dig_q];
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (CS) begin
            ps_q     <= '0;
            dig_q    <= '0;
            sh_bcd_q <= '0;
            sh_dp_q  <= '0;
            an_q     <= '0;
            seg_q    <= '0;
            dp_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ps_q     <= ps_d;
            dig_q    <= dig_d;
            sh_bcd_q <= sh_bcd_d;
            sh_dp_q  <= sh_dp_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            err_q    <= err_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;
    assign DP  = dp_q;
    assign ERR = err_q;

endmodule

// File: tb/tb_bcd_scan_disp.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_disp
//
// Directed bench for bcd_scan_disp with NDIG=4, SCAN_DIV=3. A table of
// per-cycle {inputs, expected outputs} records is replayed one clock per
// record. Records flagged lz expect a blanked slot when the design is built
// with BCD_SCAN_LZB_EN. A hand-written sequence then covers the
// leading-zero cases (0040 with and without a decimal point on digit 3).
// ---------------------------------------------------------------------------
module tb_bcd_scan_disp;

    localparam int NDIG     = 4;
    localparam int SCAN_DIV = 3;

`ifdef BCD_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        cs;
    logic        en;
    logic        latch;
    logic [15:0] bcd;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        err;

    int total;
    int bad;

    bcd_scan_disp #(
        .NDIG     (NDIG),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .CLK   (clk),
        .CS    (cs),
        .EN    (en),
        .LATCH (latch),
        .BCD   (bcd),
        .DP_IN (dp_in),
        .AN    (an),
        .SEG   (seg),
        .DP    (dp),
        .ERR   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cs;
        logic        en;
        logic        latch;
        logic [15:0] bcd;
        logic [3:0]  dpi;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        err;
        logic        lz;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int n, input logic c, input logic e, input logic l,
                       input logic [15:0] b, input logic [3:0] d,
                       input logic [3:0] a, input logic [6:0] s,
                       input logic p, input logic r, input logic z);
        vec_t v;
        v.cs = c; v.en = e; v.latch = l; v.bcd = b; v.dpi = d;
        v.an = a; v.seg = s; v.dp = p; v.err = r; v.lz = z;
        repeat (n) vq.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [3:0] ean, input logic [6:0] eseg,
                         input logic edp, input logic eerr);
        total++;
        if (an !== ean || seg !== eseg || dp !== edp || err !== eerr) begin
            bad++;
            $display("FAIL %s[%0d]: got AN=%b SEG=%h DP=%b ERR=%b, want AN=%b SEG=%h DP=%b ERR=%b",
                     name, idx, an, seg, dp, err, ean, eseg, edp, eerr);
        end
    endtask

    task automatic step(input logic c, input logic e, input logic l,
                        input logic [15:0] b, input logic [3:0] d);
        cs = c; en = e; latch = l; bcd = b; dp_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cs = 1'b1; en = 1'b0; latch = 1'b0; bcd = '0; dp_in = '0;

        // cnt cs en lt bcd       dpi    an      seg    dp err lz
        add(1, 1, 0, 0, 16'h0000, 4'h0, 4'b0000, 7'h00, 0, 0, 0); // reset
        add(1, 0, 0, 1, 16'h1234, 4'h0, 4'b0000, 7'h00, 0, 0, 0); // capture, EN low
        add(3, 0, 1, 0, 16'h1234, 4'h0, 4'b0001, 7'h66, 0, 0, 0);
        add(3, 0, 1, 0, 16'h1234, 4'h0, 4'b0010, 7'h4F, 0, 0, 0);
        add(3, 0, 1, 0, 16'h1234, 4'h0, 4'b0100, 7'h5B, 0, 0, 0);
        add(3, 0, 1, 0, 16'h1234, 4'h0, 4'b1000, 7'h06, 0, 0, 0);
        add(3, 0, 1, 0, 16'h1234, 4'h0, 4'b0001, 7'h66, 0, 0, 0); // wrap, no gap
        add(3, 0, 1, 0, 16'h1234, 4'h0, 4'b0010, 7'h4F, 0, 0, 0);
        add(1, 0, 1, 0, 16'h1234, 4'h0, 4'b0100, 7'h5B, 0, 0, 0);
        add(1, 0, 1, 1, 16'h9870, 4'h0, 4'b0100, 7'h5B, 0, 0, 0); // mid-slot capture
        add(1, 0, 1, 0, 16'h9870, 4'h0, 4'b0100, 7'h7F, 0, 0, 0); // new digit 2 = 8
        add(3, 0, 1, 0, 16'h9870, 4'h0, 4'b1000, 7'h6F, 0, 0, 0);
        add(3, 0, 1, 0, 16'h9870, 4'h0, 4'b0001, 7'h3F, 0, 0, 0);
        add(3, 0, 1, 0, 16'h9870, 4'h0, 4'b0010, 7'h07, 0, 0, 0);
        add(1, 0, 1, 0, 16'h9870, 4'h0, 4'b0100, 7'h7F, 0, 0, 0);
        add(1, 0, 1, 1, 16'h00A5, 4'h0, 4'b0100, 7'h7F, 0, 0, 0); // capture bad nibble
        add(1, 0, 1, 0, 16'h00A5, 4'h0, 4'b0100, 7'h3F, 0, 1, 1); // ERR one clock later
        add(3, 0, 1, 0, 16'h00A5, 4'h0, 4'b1000, 7'h3F, 0, 1, 1);
        add(3, 0, 1, 0, 16'h00A5, 4'h0, 4'b0001, 7'h6D, 0, 1, 0);
        add(3, 0, 1, 0, 16'h00A5, 4'h0, 4'b0010, 7'h79, 0, 1, 0); // 'E'
        add(1, 0, 1, 0, 16'h00A5, 4'h0, 4'b0100, 7'h3F, 0, 1, 1);
        add(1, 0, 1, 1, 16'h0005, 4'h4, 4'b0100, 7'h3F, 0, 1, 1); // clean value + DP2
        add(1, 0, 1, 0, 16'h0005, 4'h4, 4'b0100, 7'h3F, 1, 0, 0);
        add(1, 0, 1, 0, 16'h0005, 4'h4, 4'b1000, 7'h3F, 0, 0, 1);
        add(5, 0, 0, 0, 16'h0005, 4'h4, 4'b0000, 7'h00, 0, 0, 0); // EN low mid-slot
        add(2, 0, 1, 0, 16'h0005, 4'h4, 4'b1000, 7'h3F, 0, 0, 1); // rest of slot
        add(2, 0, 1, 0, 16'h0005, 4'h4, 4'b0001, 7'h6D, 0, 0, 0);
        add(1, 1, 1, 1, 16'h9999, 4'hF, 4'b0000, 7'h00, 0, 0, 0); // CS wins
        add(3, 0, 1, 0, 16'h9999, 4'hF, 4'b0001, 7'h3F, 0, 0, 0);
        add(1, 0, 1, 0, 16'h9999, 4'hF, 4'b0010, 7'h3F, 0, 0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            logic [3:0] ean;
            logic [6:0] eseg;
            logic       edp;
            v    = vq[i];
            ean  = v.an;
            eseg = v.seg;
            edp  = v.dp;
            if (LZB && v.lz) begin
                ean  = '0;
                eseg = '0;
                edp  = 1'b0;
            end
            step(v.cs, v.en, v.latch, v.bcd, v.dpi);
            check("vec", i, ean, eseg, edp, v.err);
        end

        // Leading-zero case: 0040 with no decimal points, one full scan.
        step(1'b1, 1'b0, 1'b0, 16'h0000, 4'h0);
        check("lz_rst", 0, 4'b0000, 7'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h0040, 4'b0000);
        for (int k = 0; k < 4 * SCAN_DIV; k++) begin
            int d;
            logic [3:0] ean;
            logic [6:0] eseg;
            d    = k / SCAN_DIV;
            ean  = 4'b0001 << d;
            eseg = (d == 1) ? 7'h66 : 7'h3F;
            if (LZB && d >= 2) begin
                ean  = '0;
                eseg = '0;
            end
            step(1'b0, 1'b1, 1'b0, 16'h0040, 4'b0000);
            check("lz_0040", k, ean, eseg, 1'b0, 1'b0);
        end

        // Same digits with DP on digit 3: nothing may be blanked.
        step(1'b0, 1'b0, 1'b1, 16'h0040, 4'b1000);
        check("lz_relatch", 0, 4'b0000, 7'h00, 1'b0, 1'b0);
        for (int k = 0; k < 4 * SCAN_DIV; k++) begin
            int d;
            logic [3:0] ean;
            d   = k / SCAN_DIV;
            ean = 4'b0001 << d;
            step(1'b0, 1'b1, 1'b0, 16'h0040, 4'b1000);
            check("lz_dp3", k, ean, (d == 1) ? 7'h66 : 7'h3F, d == 3, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

endmodule
